// File: rtl/screen_sequencer_if.sv
// Purpose: handshake bundle between the game-flow controller and its
// surroundings (input pulses in, screen selection / enables / timing out).
// Signals:
//   start, pause, game_over, winner_b : event pulses from controls / scoring
//   screen_sel                        : selected screen code (0..6)
//   *_en                              : one-hot screen block enables
//   cd_digit                          : current countdown digit
//   draw_active                       : plot window of the selected screen
// Modports: master drives the pulses, slave is the sequencer.
interface screen_sequencer_if;
  logic       start;
  logic       pause;
  logic       game_over;
  logic       winner_b;
  logic [2:0] screen_sel;
  logic       title_en;
  logic       idle_en;
  logic       pause_en;
  logic       countdown_en;
  logic       a_win_en;
  logic       b_win_en;
  logic       play_en;
  logic [3:0] cd_digit;
  logic       draw_active;

  modport master (
    output start, pause, game_over, winner_b,
    input  screen_sel, title_en, idle_en, pause_en, countdown_en,
           a_win_en, b_win_en, play_en, cd_digit, draw_active
  );

  modport slave (
    input  start, pause, game_over, winner_b,
    output screen_sel, title_en, idle_en, pause_en, countdown_en,
           a_win_en, b_win_en, play_en, cd_digit, draw_active
  );
endinterface

// File: rtl/screen_sequencer.sv
// Purpose: game-flow controller. Picks the full-screen background
// (title/idle/pause/countdown/A-win/B-win) or gameplay, runs the 1 s
// countdown and opens a one-frame plot window on every screen change
// and every countdown tick.
// Ports:
//   CLOCK_50 : system clock
//   resetn   : asynchronous active-low reset
//   bus      : screen_sequencer_if.slave (pulses in, registered screen outputs)
// Optional feature: define SCREEN_ATTRACT_EN to return from IDLE to TITLE
// after IDLE_TIMEOUT_S seconds without a start pulse.
module screen_sequencer #(
  parameter int unsigned TICKS_PER_SEC  = 50_000_000,
  parameter int unsigned COUNT_START    = 5,
  parameter int unsigned FRAME_CYCLES   = 19200,
  parameter int unsigned IDLE_TIMEOUT_S = 30
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  screen_sequencer_if.slave bus
);

  localparam int unsigned SEL_W       = 3;
  localparam int unsigned NUM_SCREENS = 7;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned PRESC_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned DRAW_W      = $clog2(FRAME_CYCLES + 1);

  // Parameter sanity checks at elaboration.
  if (COUNT_START < 1 || COUNT_START > 9) begin : g_bad_count_start
    $error("COUNT_START must be 1..9");
  end
  if (TICKS_PER_SEC < 1 || FRAME_CYCLES < 1 || IDLE_TIMEOUT_S < 1) begin : g_bad_timing
    $error("TICKS_PER_SEC, FRAME_CYCLES and IDLE_TIMEOUT_S must be >= 1");
  end

  // Encoding doubles as the screen_sel code.
  typedef enum logic [SEL_W-1:0] {
    ST_TITLE     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PAUSE     = 3'd2,
    ST_COUNTDOWN = 3'd3,
    ST_A_WON     = 3'd4,
    ST_B_WON     = 3'd5,
    ST_PLAY      = 3'd6
  } state_t;

  state_t                   r_state;
  logic [NUM_SCREENS-1:0]   r_en;
  logic [DIGIT_W-1:0]       r_cd_digit;
  logic [PRESC_W-1:0]       r_presc;
  logic [DRAW_W-1:0]        r_draw_cnt;
  logic                     r_draw_active;

  state_t                   w_state_nxt;
  logic [NUM_SCREENS-1:0]   w_en_nxt;
  logic [DIGIT_W-1:0]       w_cd_nxt;
  logic [PRESC_W-1:0]       w_presc_nxt;
  logic [DRAW_W-1:0]        w_draw_cnt_nxt;
  logic                     w_draw_active_nxt;
  logic                     w_timed;
  logic                     w_tick;
  logic                     w_timeout;
  logic                     w_reload;

`ifdef SCREEN_ATTRACT_EN
  localparam int unsigned SEC_W = (IDLE_TIMEOUT_S > 1) ? $clog2(IDLE_TIMEOUT_S + 1) : 1;
  logic [SEC_W-1:0] r_idle_sec;
  logic [SEC_W-1:0] w_idle_sec_nxt;
`endif

  // Next-state, counters and registered-output values.
  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd_digit;
    w_presc_nxt = '0;
    w_timeout   = 1'b0;

`ifdef SCREEN_ATTRACT_EN
    w_timed = (r_state == ST_COUNTDOWN) || (r_state == ST_IDLE);
`else
    w_timed = (r_state == ST_COUNTDOWN);
`endif
    w_tick = w_timed && (r_presc == PRESC_W'(TICKS_PER_SEC - 1));

`ifdef SCREEN_ATTRACT_EN
    w_timeout = w_tick && (r_state == ST_IDLE) &&
                (r_idle_sec == SEC_W'(IDLE_TIMEOUT_S - 1));
`endif

    case (r_state)
      ST_TITLE: begin
        if (bus.start) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // Start wins over a timeout landing on the same cycle.
        if (bus.start) begin
          w_state_nxt = ST_COUNTDOWN;
          w_cd_nxt    = DIGIT_W'(COUNT_START);
        end else if (w_timeout) begin
          w_state_nxt = ST_TITLE;
        end
      end
      ST_COUNTDOWN: begin
        if (w_tick) begin
          if (r_cd_digit == DIGIT_W'(1)) w_state_nxt = ST_PLAY;
          else                           w_cd_nxt    = r_cd_digit - DIGIT_W'(1);
        end
      end
      ST_PLAY: begin
        if (bus.game_over)  w_state_nxt = bus.winner_b ? ST_B_WON : ST_A_WON;
        else if (bus.pause) w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (bus.pause) w_state_nxt = ST_PLAY;
      end
      ST_A_WON, ST_B_WON: begin
        if (bus.start) w_state_nxt = ST_TITLE;
      end
      default: w_state_nxt = ST_TITLE;
    endcase

    // Prescaler only runs while staying in a timed state; any exit clears it.
    if (w_timed && (w_state_nxt == r_state))
      w_presc_nxt = w_tick ? '0 : r_presc + PRESC_W'(1);

`ifdef SCREEN_ATTRACT_EN
    w_idle_sec_nxt = '0;
    if ((r_state == ST_IDLE) && (w_state_nxt == ST_IDLE))
      w_idle_sec_nxt = w_tick ? r_idle_sec + SEC_W'(1) : r_idle_sec;
`endif

    // Redraw on every screen change and every countdown digit change.
    w_reload = (w_state_nxt != r_state) || ((r_state == ST_COUNTDOWN) && w_tick);
    if (w_reload)                w_draw_cnt_nxt = DRAW_W'(FRAME_CYCLES);
    else if (r_draw_cnt != '0)   w_draw_cnt_nxt = r_draw_cnt - DRAW_W'(1);
    else                         w_draw_cnt_nxt = r_draw_cnt;
    w_draw_active_nxt = (w_draw_cnt_nxt != '0);

    w_en_nxt = NUM_SCREENS'(1) << w_state_nxt;
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_TITLE;
      r_en          <= NUM_SCREENS'(1);
      r_cd_digit    <= DIGIT_W'(COUNT_START);
      r_presc       <= '0;
      r_draw_cnt    <= DRAW_W'(FRAME_CYCLES);
      r_draw_active <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_en          <= w_en_nxt;
      r_cd_digit    <= w_cd_nxt;
      r_presc       <= w_presc_nxt;
      r_draw_cnt    <= w_draw_cnt_nxt;
      r_draw_active <= w_draw_active_nxt;
    end
  end

`ifdef SCREEN_ATTRACT_EN
  // Idle seconds counter for the attract-mode return.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_idle_sec <= '0;
    else         r_idle_sec <= w_idle_sec_nxt;
  end
`endif

  assign bus.screen_sel   = r_state;
  assign bus.title_en     = r_en[0];
  assign bus.idle_en      = r_en[1];
  assign bus.pause_en     = r_en[2];
  assign bus.countdown_en = r_en[3];
  assign bus.a_win_en     = r_en[4];
  assign bus.b_win_en     = r_en[5];
  assign bus.play_en      = r_en[6];
  assign bus.cd_digit     = r_cd_digit;
  assign bus.draw_active  = r_draw_active;

endmodule

// File: tb/tb_screen_sequencer.sv
// Purpose: self-checking bench for screen_sequencer with small timing
// parameters (10 ticks/s, countdown from 3, 8-cycle redraw, 2 s idle timeout).
module tb_screen_sequencer;

  localparam int unsigned TPS = 10;
  localparam int unsigned CS  = 3;
  localparam int unsigned FC  = 8;
  localparam int unsigned ITO = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  screen_sequencer_if bus_if();

  screen_sequencer #(
    .TICKS_PER_SEC (TPS),
    .COUNT_START   (CS),
    .FRAME_CYCLES  (FC),
    .IDLE_TIMEOUT_S(ITO)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       pause;
    logic       game_over;
    logic       winner_b;
    logic [2:0] sel;
    logic [3:0] cd;
    logic       draw;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input logic s, input logic p, input logic g, input logic w,
                              input int sel, input int cd, input logic draw);
    vec_t v;
    v.start = s; v.pause = p; v.game_over = g; v.winner_b = w;
    v.sel = 3'(sel); v.cd = 4'(cd); v.draw = draw;
    vecs.push_back(v);
  endfunction

  // 30 countdown cycles following entry; stray pause/start/game_over must be ignored.
  function automatic void fill_countdown();
    for (int j = 1; j <= 30; j++)
      add(j == 15, j == 5, j == 25, 1'b0,
          (j == 30) ? 6 : 3,
          (j < 10) ? 3 : ((j < 20) ? 2 : 1),
          (j % 10) < 8);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0d: got %0d want %0d", name, idx, got, want);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input int sel, input int cd, input logic draw);
    logic [6:0] en_got;
    logic [6:0] en_want;
    en_got  = {bus_if.play_en, bus_if.b_win_en, bus_if.a_win_en, bus_if.countdown_en,
               bus_if.pause_en, bus_if.idle_en, bus_if.title_en};
    en_want = 7'(1) << sel;
    chk({tag, ".sel"},  idx, 8'(bus_if.screen_sel),  8'(sel));
    chk({tag, ".en"},   idx, 8'(en_got),             8'(en_want));
    chk({tag, ".cd"},   idx, 8'(bus_if.cd_digit),    8'(cd));
    chk({tag, ".draw"}, idx, 8'(bus_if.draw_active), 8'(draw));
  endtask

  task automatic step(input logic s, input logic p, input logic g, input logic w);
    bus_if.start = s; bus_if.pause = p; bus_if.game_over = g; bus_if.winner_b = w;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0; bus_if.pause = 1'b0; bus_if.game_over = 1'b0; bus_if.winner_b = 1'b0;
  endtask

  initial begin
    bus_if.start = 1'b0; bus_if.pause = 1'b0; bus_if.game_over = 1'b0; bus_if.winner_b = 1'b0;

    // Main flow table: one entry per clock edge after reset release.
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 0, 3, k < 8);
    add(1, 0, 0, 0, 1, 3, 1);
    add(0, 0, 0, 0, 1, 3, 1);
    add(0, 0, 0, 0, 1, 3, 1);
    add(1, 0, 0, 0, 3, 3, 1);
    fill_countdown();
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 6, 1, k < 8);
    add(0, 1, 0, 0, 2, 1, 1);
    add(0, 0, 1, 0, 2, 1, 1);
    add(1, 0, 0, 0, 2, 1, 1);
    add(0, 0, 0, 0, 2, 1, 1);
    add(0, 1, 0, 0, 6, 1, 1);          // reload at draw cycle 4
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 0, 6, 1, k < 8);
    add(0, 1, 1, 1, 5, 1, 1);          // game_over beats pause
    add(0, 1, 0, 0, 5, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 3, 3, 1);          // digit reloaded on countdown entry
    fill_countdown();
    add(0, 0, 1, 0, 4, 1, 1);
    add(0, 1, 0, 0, 4, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 3, 1);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].pause, vecs[i].game_over, vecs[i].winner_b);
      chk_all("vec", i, int'(vecs[i].sel), int'(vecs[i].cd), vecs[i].draw);
    end

    // Asynchronous reset in the middle of the countdown.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (18) step(0, 0, 0, 0);
    chk_all("pre_rst", 0, 3, 2, 0);
    resetn = 1'b0;
    #2;
    chk_all("async_rst", 0, 0, 3, 1);
    @(posedge clk);
    #1;
    chk_all("held_rst", 0, 0, 3, 1);
    resetn = 1'b1;
    step(0, 0, 0, 0);
    chk_all("post_rst", 0, 0, 3, 1);

    // Idle behaviour with and without the attract timeout.
    step(1, 0, 0, 0);
    chk_all("enter_idle", 0, 1, 3, 1);
`ifdef SCREEN_ATTRACT_EN
    repeat (19) step(0, 0, 0, 0);
    chk_all("idle_19", 0, 1, 3, 0);
    step(0, 0, 0, 0);
    chk_all("timeout", 0, 0, 3, 1);
    step(1, 0, 0, 0);
    repeat (19) step(0, 0, 0, 0);
    chk_all("idle_19b", 0, 1, 3, 0);
    step(1, 0, 0, 0);
    chk_all("start_on_timeout", 0, 3, 3, 1);
`else
    repeat (40) step(0, 0, 0, 0);
    chk_all("idle_hold", 0, 1, 3, 0);
    step(1, 0, 0, 0);
    chk_all("idle_start", 0, 3, 3, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
